// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared state encodings for the pipeline stall/flush sequencer
package pipe_hazard_ctrl_pkg;

  localparam int CTRL_STATE_WIDTH = 2;

  typedef enum logic [CTRL_STATE_WIDTH-1:0] {
    CTRL_IDLE        = 2'd0,
    CTRL_DIV_WAIT    = 2'd1,
    CTRL_FENCE_DRAIN = 2'd2,
    CTRL_WFI_SLEEP   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - central stall/flush sequencer for the 5-stage core
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RF_AW-1:0] id_rf_raddr1,
  input  logic [RF_AW-1:0] id_rf_raddr2,
  input  logic             id_is_fence_inst,
  input  logic             id_fence_tp,
  input  logic             id_is_wfi_inst,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic             ex_req_rf,
  input  logic [RF_AW-1:0] ex_rd_addr,
  input  logic             ex_is_div,
  input  logic             div_done,
  input  logic             bju_taken,
  input  logic             mem_valid,
  input  logic             mem_busy,
  input  logic             irq_pending,
  input  logic             trap_req,
  output logic             ld_risk,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             div_start,
  output logic             div_kill,
  output logic             refetch,
  output logic             sleeping,
  output logic [CTRL_STATE_WIDTH-1:0] ctrl_state
);

  ctrl_state_e state_q, state_d;
  logic        div_done_q, div_done_d;
  logic        fence_hit;

  assign ld_risk = id_valid & ex_valid & ex_is_load & ex_req_rf & (ex_rd_addr != '0) &
                   ((ex_rd_addr == id_rf_raddr1) | (ex_rd_addr == id_rf_raddr2));

  assign fence_hit  = (state_q == CTRL_FENCE_DRAIN) |
                      ((state_q == CTRL_IDLE) & id_valid & id_is_fence_inst);
  assign ctrl_state = state_q;
  assign sleeping   = (state_q == CTRL_WFI_SLEEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CTRL_IDLE;
      div_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_done_q <= div_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_done_d = 1'b0;
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    ex_stall   = 1'b0;
    mem_stall  = 1'b0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    ex_flush   = 1'b0;
    div_start  = 1'b0;
    div_kill   = 1'b0;
    refetch    = 1'b0;

    if (trap_req) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      ex_flush = 1'b1;
      div_kill = (state_q == CTRL_DIV_WAIT);
      state_d  = CTRL_IDLE;
    end else if (mem_busy) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
      // A divider result landing under a bus stall must survive until the bus frees up.
      div_done_d = (state_q == CTRL_DIV_WAIT) & (div_done | div_done_q);
    end else if (state_q == CTRL_DIV_WAIT) begin
      if (div_done | div_done_q) begin
        state_d = CTRL_IDLE;
      end else begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        ex_stall = 1'b1;
        ex_flush = 1'b1;
      end
    end else if ((state_q == CTRL_IDLE) & ex_valid & ex_is_div) begin
      div_start = 1'b1;
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      ex_flush  = 1'b1;
      state_d   = CTRL_DIV_WAIT;
    end else if (bju_taken) begin
      // The fence/wfi waiting in ID is wrong-path once flushed, so drop back to IDLE.
      if_flush = 1'b1;
      id_flush = 1'b1;
      state_d  = CTRL_IDLE;
    end else if (ld_risk) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
      id_flush = 1'b1;
    end else if (fence_hit) begin
      if (ex_valid | mem_valid) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        id_flush = 1'b1;
        state_d  = CTRL_FENCE_DRAIN;
      end else begin
        refetch  = id_fence_tp;
        if_flush = id_fence_tp;
        state_d  = CTRL_IDLE;
      end
    end else if ((state_q == CTRL_IDLE) & id_valid & id_is_wfi_inst) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
      id_flush = 1'b1;
      state_d  = CTRL_WFI_SLEEP;
    end else if (state_q == CTRL_WFI_SLEEP) begin
      if (irq_pending) begin
        state_d = CTRL_IDLE;
      end else begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        id_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_is_fence_inst, id_fence_tp, id_is_wfi_inst;
  logic [4:0] id_rf_raddr1, id_rf_raddr2, ex_rd_addr;
  logic       ex_valid, ex_is_load, ex_req_rf, ex_is_div, div_done, bju_taken;
  logic       mem_valid, mem_busy, irq_pending, trap_req;
  logic       ld_risk, if_stall, id_stall, ex_stall, mem_stall;
  logic       if_flush, id_flush, ex_flush, div_start, div_kill, refetch, sleeping;
  logic [1:0] ctrl_state;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [11:0] M_LD  = 12'h800;
  localparam logic [11:0] M_IFS = 12'h400;
  localparam logic [11:0] M_IDS = 12'h200;
  localparam logic [11:0] M_EXS = 12'h100;
  localparam logic [11:0] M_MS  = 12'h080;
  localparam logic [11:0] M_IFF = 12'h040;
  localparam logic [11:0] M_IDF = 12'h020;
  localparam logic [11:0] M_EXF = 12'h010;
  localparam logic [11:0] M_DS  = 12'h008;
  localparam logic [11:0] M_DK  = 12'h004;
  localparam logic [11:0] M_RF  = 12'h002;
  localparam logic [11:0] M_SL  = 12'h001;

  localparam logic [11:0] LU_STALL  = M_LD | M_IFS | M_IDS | M_IDF;
  localparam logic [11:0] DIV_STALL = M_IFS | M_IDS | M_EXS | M_EXF;
  localparam logic [11:0] ID_HOLD   = M_IFS | M_IDS | M_IDF;
  localparam logic [11:0] ALL_STALL = M_IFS | M_IDS | M_EXS | M_MS;

  pipe_hazard_ctrl #(.RF_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rf_raddr1(id_rf_raddr1), .id_rf_raddr2(id_rf_raddr2),
    .id_is_fence_inst(id_is_fence_inst), .id_fence_tp(id_fence_tp), .id_is_wfi_inst(id_is_wfi_inst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_req_rf(ex_req_rf), .ex_rd_addr(ex_rd_addr),
    .ex_is_div(ex_is_div), .div_done(div_done), .bju_taken(bju_taken),
    .mem_valid(mem_valid), .mem_busy(mem_busy), .irq_pending(irq_pending), .trap_req(trap_req),
    .ld_risk(ld_risk), .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
    .div_start(div_start), .div_kill(div_kill), .refetch(refetch), .sleeping(sleeping),
    .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_valid = 0; id_is_fence_inst = 0; id_fence_tp = 0; id_is_wfi_inst = 0;
    id_rf_raddr1 = 0; id_rf_raddr2 = 0; ex_rd_addr = 0;
    ex_valid = 0; ex_is_load = 0; ex_req_rf = 0; ex_is_div = 0; div_done = 0;
    bju_taken = 0; mem_valid = 0; mem_busy = 0; irq_pending = 0; trap_req = 0;
  endtask

  task automatic chk(input string tag, input logic [11:0] exp_out, input logic [1:0] exp_st);
    logic [11:0] obs;
    #1;
    obs = {ld_risk, if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush,
           div_start, div_kill, refetch, sleeping};
    vectors++;
    assert (obs === exp_out) else begin
      miscompares++;
      $error("FAIL %s outputs: observed %h expected %h", tag, obs, exp_out);
    end
    vectors++;
    assert (ctrl_state === exp_st) else begin
      miscompares++;
      $error("FAIL %s state: observed %0d expected %0d", tag, ctrl_state, exp_st);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    id_valid = 1; id_rf_raddr1 = 5; id_rf_raddr2 = 1;
    ex_valid = 1; ex_is_load = 1; ex_req_rf = 1; ex_rd_addr = rd;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    chk("reset", 12'h000, 2'd0);
    next_cycle();
    rst_n = 1;
    next_cycle();

    // load-use hazard
    set_load_use(5);
    chk("ldu_rs1", LU_STALL, 2'd0);
    next_cycle();
    ex_valid = 0; ex_is_load = 0; mem_valid = 1;
    chk("ldu_bubble_done", 12'h000, 2'd0);
    next_cycle(); clear_inputs();
    set_load_use(1);
    chk("ldu_rs2", LU_STALL, 2'd0);
    next_cycle();
    set_load_use(0);
    id_rf_raddr1 = 0;
    chk("ldu_x0", 12'h000, 2'd0);
    next_cycle();
    set_load_use(5); ex_is_load = 0;
    chk("ldu_not_load", 12'h000, 2'd0);
    next_cycle(); clear_inputs();

    // divide: start T0, done T33
    ex_valid = 1; ex_is_div = 1;
    chk("div_t0", M_DS | DIV_STALL, 2'd0);
    for (int t = 1; t <= 32; t++) begin
      next_cycle();
      chk($sformatf("div_t%0d", t), DIV_STALL, 2'd1);
    end
    next_cycle();
    div_done = 1;
    chk("div_t33", 12'h000, 2'd1);
    next_cycle(); clear_inputs();
    chk("div_t34", 12'h000, 2'd0);
    next_cycle();

    // div_done held across mem_busy
    ex_valid = 1; ex_is_div = 1;
    chk("divmb_t0", M_DS | DIV_STALL, 2'd0);
    next_cycle();
    chk("divmb_t1", DIV_STALL, 2'd1);
    next_cycle();
    mem_busy = 1; div_done = 1;
    chk("divmb_t2", ALL_STALL, 2'd1);
    next_cycle();
    div_done = 0;
    chk("divmb_t3", ALL_STALL, 2'd1);
    next_cycle();
    mem_busy = 0;
    chk("divmb_t4", 12'h000, 2'd1);
    next_cycle(); clear_inputs();
    chk("divmb_t5", 12'h000, 2'd0);
    next_cycle();

    // trap during divide at T10
    ex_valid = 1; ex_is_div = 1;
    chk("divtrap_t0", M_DS | DIV_STALL, 2'd0);
    for (int t = 1; t <= 9; t++) begin
      next_cycle();
      chk($sformatf("divtrap_t%0d", t), DIV_STALL, 2'd1);
    end
    next_cycle();
    trap_req = 1;
    chk("divtrap_t10", M_IFF | M_IDF | M_EXF | M_DK, 2'd1);
    next_cycle(); clear_inputs();
    chk("divtrap_t11", 12'h000, 2'd0);
    next_cycle();

    // fence.i draining EX then MEM
    id_valid = 1; id_is_fence_inst = 1; id_fence_tp = 1; ex_valid = 1; mem_valid = 1;
    chk("fencei_enter", ID_HOLD, 2'd0);
    next_cycle();
    ex_valid = 0;
    chk("fencei_drain1", ID_HOLD, 2'd2);
    next_cycle();
    mem_valid = 0;
    chk("fencei_release", M_RF | M_IFF, 2'd2);
    next_cycle(); clear_inputs();
    chk("fencei_idle", 12'h000, 2'd0);
    next_cycle();

    // plain fence with empty pipe releases at once
    id_valid = 1; id_is_fence_inst = 1;
    chk("fence_immediate", 12'h000, 2'd0);
    next_cycle(); clear_inputs();
    chk("fence_stays_idle", 12'h000, 2'd0);
    next_cycle();

    // wfi, irq after 5 sleeping cycles
    id_valid = 1; id_is_wfi_inst = 1;
    chk("wfi_enter", ID_HOLD, 2'd0);
    for (int t = 1; t <= 5; t++) begin
      next_cycle();
      chk($sformatf("wfi_sleep%0d", t), M_SL | ID_HOLD, 2'd3);
    end
    next_cycle();
    irq_pending = 1;
    chk("wfi_irq", M_SL, 2'd3);
    next_cycle(); clear_inputs();
    chk("wfi_idle", 12'h000, 2'd0);
    next_cycle();

    // trap wakes wfi
    id_valid = 1; id_is_wfi_inst = 1;
    chk("wfitrap_enter", ID_HOLD, 2'd0);
    next_cycle();
    trap_req = 1;
    chk("wfitrap_exit", M_SL | M_IFF | M_IDF | M_EXF, 2'd3);
    next_cycle(); clear_inputs();
    chk("wfitrap_idle", 12'h000, 2'd0);
    next_cycle();

    // branch redirect vs load-use, with and without mem_busy
    set_load_use(5); bju_taken = 1;
    chk("bju_over_ldu", M_LD | M_IFF | M_IDF, 2'd0);
    next_cycle();
    mem_busy = 1;
    chk("membusy_over_bju", M_LD | ALL_STALL, 2'd0);
    next_cycle(); clear_inputs();

    // async reset mid-divide
    ex_valid = 1; ex_is_div = 1;
    chk("divrst_t0", M_DS | DIV_STALL, 2'd0);
    next_cycle();
    chk("divrst_t1", DIV_STALL, 2'd1);
    clear_inputs();
    rst_n = 0;
    chk("divrst_reset", 12'h000, 2'd0);
    next_cycle();
    rst_n = 1;
    next_cycle();
    chk("divrst_after", 12'h000, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core (IF, ID, EX, MEM, WB). It performs the following functions:
- Detects load-use hazards and drives ld_risk into the decode stage.
- Serialises the multi-cycle divider, fence drains and WFI sleep.
- Applies branch and trap flushes.

It owns every pipeline-register hold/bubble control; stage registers only obey it.

Parameters:
RF_AW, 5, register-file address width (matches `RF_ADDR_WIDTH)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a valid instruction
id_rf_raddr1  in  RF_AW  ID source 1 address
id_rf_raddr2  in  RF_AW  ID source 2 address
id_is_fence_inst  in  1  decoded fence in ID
id_fence_tp  in  1  1 = fence.i, 0 = fence
id_is_wfi_inst  in  1  decoded wfi in ID
ex_valid  in  1  EX holds a valid instruction
ex_is_load  in  1  EX instruction is a load
ex_req_rf  in  1  EX instruction writes rd
ex_rd_addr  in  RF_AW  EX destination
ex_is_div  in  1  EX instruction is div/rem
div_done  in  1  divider result valid (1-cycle pulse)
bju_taken  in  1  EX resolved redirect (taken branch/jump)
mem_valid  in  1  MEM holds a valid instruction
mem_busy  in  1  data bus access outstanding in MEM
irq_pending  in  1  enabled interrupt pending
trap_req  in  1  trap/mret commit, PC redirect this cycle
ld_risk  out  1  load-use hazard, disables EX forwarding in ID
if_stall  out  1  hold PC
id_stall  out  1  hold IF/ID register
ex_stall  out  1  hold ID/EX register
mem_stall  out  1  hold EX/MEM register
if_flush  out  1  load bubble into IF/ID
id_flush  out  1  load bubble into ID/EX
ex_flush  out  1  load bubble into EX/MEM
div_start  out  1  start divider (1-cycle pulse)
div_kill  out  1  abort divider
refetch  out  1  fence.i release: PC unit refetches from ID pc+4
sleeping  out  1  core in WFI sleep
ctrl_state  out  2  FSM state, for debug/verification

Behaviour:
Reset:
- State IDLE (0).
- All outputs 0.
- FSM register only; everything else is combinational from state and inputs.

States: IDLE=0, DIV_WAIT=1, FENCE_DRAIN=2, WFI_SLEEP=3.

ld_risk (combinational, any state):
- Asserted when id_valid & ex_valid & ex_is_load & ex_req_rf & ex_rd_addr!=0 & (ex_rd_addr==raddr1 | ex_rd_addr==raddr2).

Per-cycle priority, highest first; only the first matching row drives stalls/flushes:
1. trap_req:
   - if_flush=id_flush=ex_flush=1.
   - div_kill=1 if state==DIV_WAIT.
   - Next state IDLE from any state.
   - Stalls 0.
2. mem_busy: if_stall=id_stall=ex_stall=mem_stall=1; state unchanged.
3. DIV_WAIT:
   - if_stall=id_stall=ex_stall=1, ex_flush=1.
   - On div_done: all four 0, result advances, next IDLE.
4. IDLE & ex_valid & ex_is_div:
   - div_start=1.
   - if_stall=id_stall=ex_stall=1, ex_flush=1.
   - Next DIV_WAIT.
   - Minimum div occupancy: 2 cycles.
5. bju_taken: if_flush=id_flush=1. Overrides ld_risk, fence and wfi in the same cycle.
6. ld_risk: if_stall=id_stall=1, id_flush=1; exactly one bubble, next cycle the load is in MEM.
7. FENCE_DRAIN:
   - if_stall=id_stall=1, id_flush=1 while ex_valid|mem_valid.
   - When both are 0: release the fence into EX and go IDLE.
   - If id_fence_tp=1: refetch=1 and if_flush=1.
8. IDLE & id_valid & id_is_fence_inst:
   - If ex_valid|mem_valid: apply row 7 stalls, next FENCE_DRAIN.
   - Otherwise: release immediately, including the row 7 fence.i actions.
9. IDLE & id_valid & id_is_wfi_inst:
   - if_stall=id_stall=1, id_flush=1.
   - Next WFI_SLEEP.
10. WFI_SLEEP:
    - sleeping=1; same stalls as row 9.
    - On irq_pending: stalls 0, wfi advances as a nop, next IDLE.
    - trap_req also exits (row 1).

Further rules:
- ctrl_state reflects the registered state.
- mem_busy in DIV_WAIT also asserts mem_stall; div_done arriving then is held as a flag until mem_busy drops.
- Async reset mid-divide returns to IDLE; no div_kill is issued (divider is also reset).

Decomposition:
- Add state encodings CTRL_IDLE/DIV_WAIT/FENCE_DRAIN/WFI_SLEEP and CTRL_STATE_WIDTH=2 to defines.v.
- No sub-module: the hazard detect is a one-line compare, so the block stays flat.

Test Plan:
1. Load-use: ex lw x5, ID add x6,x5,x1 -> ld_risk=1, if_stall=id_stall=id_flush=1 for exactly 1 cycle; with rd=x0 -> no stall.
2. Divide: ex_is_div at T0, div_done at T33 -> div_start at T0 only; ctrl_state=1 T1..T33; stalls T0..T32; IDLE at T34.
3. Trap during divide: trap_req at T10 -> div_kill=1, three flushes at T10, IDLE at T11.
4. fence.i with ex_valid=1, mem_valid=1 draining over 2 cycles -> FENCE_DRAIN for 2 cycles; then refetch=1 and if_flush=1 for one cycle.
5. WFI then irq_pending after 5 cycles -> sleeping=1 for 5 cycles, release on the irq cycle.
6. bju_taken together with ld_risk and mem_busy=0 -> if_flush=id_flush=1, if_stall=0; repeat with mem_busy=1 -> all stalls, no flush.
